sevenseg_scan_mux: RTL and testbench
====================================

Name: sevenseg_scan_mux

Overview:
- Time-multiplexed driver for an NUM_DIGITS-digit common-anode 7-segment display.
- Sits downstream of the bin-to-BCD splitter and the per-digit flags (minus/blank) in the calculator display path.
- Latches a new display frame on a load strobe, applies it only at a frame boundary so digits never tear, and scans digits with a dead-time gap between them to prevent ghosting.
- Drives registered anode enables and segment patterns; segment encoding is delegated to sevenseg_encode.

Parameters:
- NUM_DIGITS, 4: number of digits scanned, >=2.
- DIGIT_CYCLES, 50000: clk cycles each digit is lit, >=1; default gives 1 kHz per digit at 50 MHz.
- DEAD_CYCLES, 500: clk cycles with all anodes off between digits, >=0; 0 removes the dead phase.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: reset, synchronous, active-low.
- load, in, 1: single-cycle strobe; captures digit_val/digit_minus/digit_blank into the pending buffer.
- digit_val, in, 4*NUM_DIGITS: BCD per digit; digit i is at [4i+3:4i]; digit 0 is the rightmost (units).
- digit_minus, in, NUM_DIGITS: 1 shows '-' on digit i.
- digit_blank, in, NUM_DIGITS: 1 turns digit i off; has priority over minus.
- an, out, NUM_DIGITS: anode enables, active-low, one-hot-low or all 1.
- seg, out, 7: {a,b,c,d,e,f,g}, active-low.
- frame_done, out, 1: one-cycle pulse at each frame boundary.
- pending, out, 1: a loaded frame is waiting to be shown.

Behaviour:
- Clocking and reset: one clock domain (clk); reset is synchronous and active-low (rst_n).
- Reset values:
  - an = all 1; seg = 7'h7F; frame_done = 0; pending = 0.
  - Active buffer: every digit blank.
  - State DEAD, digit index = NUM_DIGITS-1, phase counter = 0.
- State machine with two states:
  - LIT: lasts DIGIT_CYCLES cycles, then goes to DEAD (or straight to the next LIT when DEAD_CYCLES = 0).
  - DEAD: lasts DEAD_CYCLES cycles, then goes to LIT of index+1 mod NUM_DIGITS.
  - After reset the first DEAD lasts max(DEAD_CYCLES,1) cycles, then LIT digit 0 begins.
- Frame boundary: the cycle in which the index wraps from NUM_DIGITS-1 to 0.
  - frame_done = 1 for exactly that cycle.
  - If pending = 1, the pending buffer copies into the active buffer and pending clears.
- Load handling:
  - load sets pending and overwrites the pending buffer; with multiple loads in a frame, the last one wins.
  - load in the same cycle as a boundary: the load data bypasses straight into the active buffer and pending ends at 0.
  - Inputs are ignored when load = 0.
- Output registers and latency:
  - an and seg are registered and reflect the state/index with 1-cycle latency.
  - LIT: an[index] = 0, all other anodes 1; seg = sevenseg_encode(active val, minus, blank) for that index.
  - DEAD: an = all 1; seg = 7'h7F.
  - Never more than one anode low in any cycle.
- Encoder mapping:
  - An active val > 9 with blank = 0 and minus = 0 gives 7'h7F (encoder default); the anode is still driven.
- Counter:
  - Width is $clog2(max(DIGIT_CYCLES, DEAD_CYCLES, 2)).
  - Counts 0 to N-1 and clears on each state change; no wrap-around artefacts.
- Reset mid-scan: on the next edge all outputs and state return to their reset values; the pending and active buffers are discarded.

Decomposition:
- Package sevenseg_pkg:
  - SEG_BLANK = 7'h7F and SEG_MINUS = 7'h7E constants.
  - State encoding constants LIT/DEAD.
  - localparam helper for counter width.
- Sub-module: one instance of sevenseg_encode on the selected active-buffer digit; this module has no other sub-modules.

Test Plan (NUM_DIGITS=4, DIGIT_CYCLES=4, DEAD_CYCLES=2; frame = 24 cycles):
- Reset check: assert rst_n=0 for 3 cycles, then release. Required: an=4'hF, seg=7'h7F, frame_done=0 during reset. First frame_done pulses 2 cycles after release. an=4'b1110 holds for 4 cycles, then 2 cycles of 4'hF.
- Load before first boundary: load digit_val=16'h0042, minus=0, blank=4'b1100. Required: digit0 seg=7'b001_0010 ('2') and digit1 seg=7'b100_1100 ('4'). Digits 2 and 3 show 7'h7F with an[2], an[3] low in their slots.
- Tearing check: load 16'h0017 mid-frame while 16'h0042 is shown. Required: pending=1 and the current frame still shows 4/2 until frame_done. At the boundary pending=0 and the next frame shows 1/7.
- Collision: load 16'h0009 in the exact frame_done cycle. Required: the very next LIT digit0 shows 7'b000_0100 ('9') and pending stays 0.
- Minus/blank priority: digit3 minus=1, blank=0 gives seg=7'h7E. With minus=1, blank=1 the digit gives 7'h7F. digit_val=4'hA with no flags gives 7'h7F.
- Dead time and reset: DEAD_CYCLES=0 build gives no all-1 gap between digits. Asserting rst_n=0 while LIT digit2 returns an=4'hF and seg=7'h7F on the next edge and clears pending.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the multiplexed 7-segment display driver.
// Segment patterns are {a,b,c,d,e,f,g}, active-low.
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h7E;

    typedef enum logic {
        LIT  = 1'b0,
        DEAD = 1'b1
    } scan_state_e;

    // Phase counter must hold the longer of the lit and dead phases (at least 1 bit).
    function automatic int cnt_width(input int digit_cycles, input int dead_cycles);
        int m;
        m = (digit_cycles > dead_cycles) ? digit_cycles : dead_cycles;
        if (m < 2) begin
            m = 2;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sevenseg_encode.sv
// BCD digit to active-low segment pattern, with blank and minus overrides.
// Blank beats minus; non-decimal codes render as an unlit digit.
module sevenseg_encode
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_val,
    input  logic       i_minus,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    logic [6:0] w_seg;

    always_comb begin
        w_seg = SEG_BLANK;
        if (i_blank) begin
            w_seg = SEG_BLANK;
        end else if (i_minus) begin
            w_seg = SEG_MINUS;
        end else begin
            case (i_val)
                4'd0:    w_seg = 7'h01;
                4'd1:    w_seg = 7'h4F;
                4'd2:    w_seg = 7'h12;
                4'd3:    w_seg = 7'h06;
                4'd4:    w_seg = 7'h4C;
                4'd5:    w_seg = 7'h24;
                4'd6:    w_seg = 7'h20;
                4'd7:    w_seg = 7'h0F;
                4'd8:    w_seg = 7'h00;
                4'd9:    w_seg = 7'h04;
                default: w_seg = SEG_BLANK;
            endcase
        end
    end

    assign o_seg = w_seg;

endmodule

// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed common-anode display scanner with tear-free frame loading
// and an all-anodes-off dead phase between digits to suppress ghosting.
module sevenseg_scan_mux
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 50000,
    parameter int DEAD_CYCLES  = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digit_val,
    input  logic [NUM_DIGITS-1:0]   digit_minus,
    input  logic [NUM_DIGITS-1:0]   digit_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int CNT_W    = cnt_width(DIGIT_CYCLES, DEAD_CYCLES);
    localparam int IDX_W    = $clog2(NUM_DIGITS);
    localparam int DEAD_LEN = (DEAD_CYCLES > 0) ? DEAD_CYCLES : 1;

    localparam logic [CNT_W-1:0] LIT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    scan_state_e             r_state;
    scan_state_e             w_state_next;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_next;
    logic [IDX_W-1:0]        w_idx_inc;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_wrap;

    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_minus;
    logic [NUM_DIGITS-1:0]   r_pend_blank;
    logic                    r_pending;
    logic [4*NUM_DIGITS-1:0] r_act_val;
    logic [NUM_DIGITS-1:0]   r_act_minus;
    logic [NUM_DIGITS-1:0]   r_act_blank;

    logic [3:0]              w_val_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_an_lit;
    logic [3:0]              w_sel_val;
    logic                    w_sel_minus;
    logic                    w_sel_blank;
    logic [6:0]              w_enc_seg;

    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [6:0]              w_seg_next;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_val_arr[gi] = r_act_val[4*gi +: 4];
            assign w_an_lit[gi]  = (r_idx != IDX_W'(gi));
        end
    endgenerate

    assign w_sel_val   = w_val_arr[r_idx];
    assign w_sel_minus = r_act_minus[r_idx];
    assign w_sel_blank = r_act_blank[r_idx];
    assign w_idx_inc   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

    sevenseg_encode u_encode (
        .i_val   (w_sel_val),
        .i_minus (w_sel_minus),
        .i_blank (w_sel_blank),
        .o_seg   (w_enc_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= DEAD;
            r_idx   <= IDX_LAST;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A DEAD phase always lasts at least one cycle so the post-reset entry works without a dead time.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_cnt_next   = r_cnt + 1'b1;
        w_wrap       = 1'b0;
        case (r_state)
            LIT: begin
                if (r_cnt == LIT_LAST) begin
                    w_cnt_next = '0;
                    if (DEAD_CYCLES == 0) begin
                        w_idx_next = w_idx_inc;
                        w_wrap     = (r_idx == IDX_LAST);
                    end else begin
                        w_state_next = DEAD;
                    end
                end
            end
            DEAD: begin
                if (r_cnt == DEAD_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = LIT;
                    w_idx_next   = w_idx_inc;
                    w_wrap       = (r_idx == IDX_LAST);
                end
            end
            default: begin
                w_state_next = DEAD;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_an_next  = '1;
        w_seg_next = SEG_BLANK;
        if (r_state == LIT) begin
            w_an_next  = w_an_lit;
            w_seg_next = w_enc_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    // A load landing on the boundary goes straight to the active buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_val   <= '0;
            r_pend_minus <= '0;
            r_pend_blank <= '0;
            r_pending    <= 1'b0;
            r_act_val    <= '0;
            r_act_minus  <= '0;
            r_act_blank  <= '1;
        end else if (w_wrap) begin
            if (load) begin
                r_act_val   <= digit_val;
                r_act_minus <= digit_minus;
                r_act_blank <= digit_blank;
            end else if (r_pending) begin
                r_act_val   <= r_pend_val;
                r_act_minus <= r_pend_minus;
                r_act_blank <= r_pend_blank;
            end
            r_pending <= 1'b0;
        end else if (load) begin
            r_pend_val   <= digit_val;
            r_pend_minus <= digit_minus;
            r_pend_blank <= digit_blank;
            r_pending    <= 1'b1;
        end
    end

    assign an      = r_an;
    assign seg     = r_seg;
    assign pending = r_pending;
    // Held reset parks the scanner on a boundary when DEAD_CYCLES is 0; keep the pulse quiet then.
    assign frame_done = w_wrap & rst_n;

endmodule

// File: tb/tb_sevenseg_scan_mux.sv
// Randomised and directed bench for sevenseg_scan_mux: two builds (dead time 2 and 0)
// checked every cycle against a timeline model of the scan and frame buffers.
module tb_sevenseg_scan_mux;

    localparam int N      = 4;
    localparam int DIG    = 4;
    localparam int DEAD_A = 2;
    localparam int DEAD_B = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digit_val;
    logic [3:0]  digit_minus;
    logic [3:0]  digit_blank;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        fd_a, fd_b, pend_a, pend_b;

    int n_checks = 0;
    int n_errors = 0;
    int gap_b    = 0;

    always #5 clk = ~clk;

    sevenseg_scan_mux #(.NUM_DIGITS(N), .DIGIT_CYCLES(DIG), .DEAD_CYCLES(DEAD_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(load), .digit_val(digit_val),
        .digit_minus(digit_minus), .digit_blank(digit_blank),
        .an(an_a), .seg(seg_a), .frame_done(fd_a), .pending(pend_a)
    );

    sevenseg_scan_mux #(.NUM_DIGITS(N), .DIGIT_CYCLES(DIG), .DEAD_CYCLES(DEAD_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(load), .digit_val(digit_val),
        .digit_minus(digit_minus), .digit_blank(digit_blank),
        .an(an_b), .seg(seg_b), .frame_done(fd_b), .pending(pend_b)
    );

    // Reference model state, one slot per build; m_t counts cycles since reset release.
    int          m_t    [2];
    logic [3:0]  m_an   [2];
    logic [6:0]  m_seg  [2];
    bit          m_pend [2];
    logic [15:0] m_pval [2];
    logic [15:0] m_aval [2];
    logic [3:0]  m_pmin [2];
    logic [3:0]  m_amin [2];
    logic [3:0]  m_pblk [2];
    logic [3:0]  m_ablk [2];
    logic [6:0]  last_seg_a [N];

    string lit_segs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                             "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int dead_of(input int k);
        return (k == 0) ? DEAD_A : DEAD_B;
    endfunction

    function automatic int first_dead(input int k);
        return (dead_of(k) > 0) ? dead_of(k) : 1;
    endfunction

    function automatic int slot_of(input int k);
        return DIG + dead_of(k);
    endfunction

    function automatic bit lit_at(input int k, input int t, output int d);
        int u;
        d = 0;
        if (t < first_dead(k)) return 1'b0;
        u = t - first_dead(k);
        d = (u / slot_of(k)) % N;
        return (u % slot_of(k)) < DIG;
    endfunction

    function automatic bit bnd_at(input int k, input int t);
        if (t == first_dead(k) - 1) return 1'b1;
        return (t >= first_dead(k)) && (((t - first_dead(k) + 1) % (N * slot_of(k))) == 0);
    endfunction

    function automatic logic [6:0] seg_ref(input logic [3:0] v, input logic mi, input logic bl);
        logic [6:0] s;
        byte        ch;
        s = 7'h7F;
        if (bl) return 7'h7F;
        if (mi) return 7'h7E;
        if (v > 4'd9) return 7'h7F;
        for (int i = 0; i < lit_segs[v].len(); i++) begin
            ch = lit_segs[v][i];
            s[6 - int'(ch - 8'h61)] = 1'b0;
        end
        return s;
    endfunction

    task automatic model_reset(input int k);
        m_t[k]    = 0;
        m_an[k]   = 4'hF;
        m_seg[k]  = 7'h7F;
        m_pend[k] = 1'b0;
        m_pval[k] = '0;
        m_pmin[k] = '0;
        m_pblk[k] = '0;
        m_aval[k] = '0;
        m_amin[k] = '0;
        m_ablk[k] = 4'hF;
    endtask

    task automatic model_edge(input int k);
        int d;
        if (lit_at(k, m_t[k], d)) begin
            m_an[k]  = ~(4'b0001 << d);
            m_seg[k] = seg_ref(m_aval[k][4*d +: 4], m_amin[k][d], m_ablk[k][d]);
        end else begin
            m_an[k]  = 4'hF;
            m_seg[k] = 7'h7F;
        end
        if (bnd_at(k, m_t[k])) begin
            if (load) begin
                m_aval[k] = digit_val;
                m_amin[k] = digit_minus;
                m_ablk[k] = digit_blank;
            end else if (m_pend[k]) begin
                m_aval[k] = m_pval[k];
                m_amin[k] = m_pmin[k];
                m_ablk[k] = m_pblk[k];
            end
            m_pend[k] = 1'b0;
        end else if (load) begin
            m_pval[k] = digit_val;
            m_pmin[k] = digit_minus;
            m_pblk[k] = digit_blank;
            m_pend[k] = 1'b1;
        end
        m_t[k]++;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        logic [3:0] o_an;
        logic [6:0] o_seg;
        logic       o_fd, o_pend;
        #1;
        for (int k = 0; k < 2; k++) begin
            o_an   = (k == 0) ? an_a   : an_b;
            o_seg  = (k == 0) ? seg_a  : seg_b;
            o_fd   = (k == 0) ? fd_a   : fd_b;
            o_pend = (k == 0) ? pend_a : pend_b;
            check_eq($sformatf("an[%0d] t=%0d", k, m_t[k]), o_an, m_an[k]);
            check_eq($sformatf("seg[%0d] t=%0d", k, m_t[k]), o_seg, m_seg[k]);
            check_eq($sformatf("frame_done[%0d] t=%0d", k, m_t[k]), o_fd,
                     (rst_n && bnd_at(k, m_t[k])) ? 1'b1 : 1'b0);
            check_eq($sformatf("pending[%0d] t=%0d", k, m_t[k]), o_pend, m_pend[k]);
        end
        if (rst_n) begin
            for (int d = 0; d < N; d++) begin
                if (!an_a[d]) last_seg_a[d] = seg_a;
            end
            if (m_t[1] >= 2 && an_b == 4'hF) gap_b++;
        end
        if (load) begin
            $display("load t=%0d rst_n=%0b val=%h minus=%b blank=%b", m_t[0], rst_n,
                     digit_val, digit_minus, digit_blank);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            else model_edge(k);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        load        = 1'b0;
        digit_val   = 16'($urandom);
        digit_minus = 4'($urandom);
        digit_blank = 4'($urandom);
        tick();
    endtask

    task automatic load_tick(input logic [15:0] v, input logic [3:0] mi, input logic [3:0] bl);
        digit_val   = v;
        digit_minus = mi;
        digit_blank = bl;
        load        = 1'b1;
        tick();
        load        = 1'b0;
    endtask

    task automatic wait_bnd_a();
        int n;
        n = 0;
        while (!bnd_at(0, m_t[0]) && n < 100) begin
            idle();
            n++;
        end
        check_eq("wait_boundary", (n < 100) ? 1'b1 : 1'b0, 1'b1);
    endtask

    task automatic observe_frame();
        for (int d = 0; d < N; d++) last_seg_a[d] = 7'h55;
        repeat (N * (DIG + DEAD_A)) idle();
    endtask

    initial begin
        int d;
        int n;
        rst_n       = 1'b0;
        load        = 1'b0;
        digit_val   = '0;
        digit_minus = '0;
        digit_blank = '0;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) model_reset(k);
        repeat (3) tick();
        rst_n = 1'b1;

        // First frame: 0042 with the upper two digits blanked.
        load_tick(16'h0042, 4'b0000, 4'b1100);
        wait_bnd_a();
        idle();
        observe_frame();
        check_eq("f42_d0", last_seg_a[0], 7'h12);
        check_eq("f42_d1", last_seg_a[1], 7'h4C);
        check_eq("f42_d2", last_seg_a[2], 7'h7F);
        check_eq("f42_d3", last_seg_a[3], 7'h7F);

        // Mid-frame load must wait for the boundary.
        load_tick(16'h0017, 4'b0000, 4'b1100);
        check_eq("tear_pending", pend_a, 1'b1);
        for (int i = 0; i < N; i++) last_seg_a[i] = 7'h55;
        wait_bnd_a();
        check_eq("tear_hold_d1", last_seg_a[1], 7'h4C);
        idle();
        check_eq("tear_swapped", pend_a, 1'b0);
        observe_frame();
        check_eq("f17_d0", last_seg_a[0], 7'h0F);
        check_eq("f17_d1", last_seg_a[1], 7'h4F);

        // Load exactly on the boundary bypasses into the active frame.
        wait_bnd_a();
        load_tick(16'h0009, 4'b0000, 4'b1110);
        check_eq("coll_pending", pend_a, 1'b0);
        observe_frame();
        check_eq("coll_d0", last_seg_a[0], 7'h04);

        // Flag priority and out-of-range BCD.
        load_tick(16'h300A, 4'b1100, 4'b0100);
        wait_bnd_a();
        idle();
        observe_frame();
        check_eq("prio_d0_hexA", last_seg_a[0], 7'h7F);
        check_eq("prio_d1_zero", last_seg_a[1], 7'h01);
        check_eq("prio_d2_blank", last_seg_a[2], 7'h7F);
        check_eq("prio_d3_minus", last_seg_a[3], 7'h7E);

        check_eq("nodead_gap", 16'(gap_b), 16'd0);

        // Reset while digit 2 is lit, with a frame pending.
        n = 0;
        while (!(lit_at(0, m_t[0], d) && d == 2) && n < 100) begin
            idle();
            n++;
        end
        check_eq("wait_digit2", (n < 100) ? 1'b1 : 1'b0, 1'b1);
        load_tick(16'h5555, 4'b0000, 4'b0000);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        check_eq("rst_an", an_a, 4'hF);
        check_eq("rst_seg", seg_a, 7'h7F);
        check_eq("rst_pending", pend_a, 1'b0);

        // Random traffic with occasional resets.
        repeat (400) begin
            rst_n       = ($urandom_range(0, 149) != 0);
            load        = ($urandom_range(0, 5) == 0);
            digit_val   = 16'($urandom);
            digit_minus = 4'($urandom) & 4'($urandom);
            digit_blank = 4'($urandom) & 4'($urandom);
            tick();
        end
        rst_n = 1'b1;
        repeat (30) idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
